// File: rtl/qc_pkg.sv
// qc_pkg: shared complex amplitude type, FSM states and rounding helpers for the gate/state engine.
package qc_pkg;

  localparam int FRAC = 6;

  typedef struct packed {
    logic signed [7:0] a;
    logic signed [7:0] b;
  } complexNum;

  typedef struct packed {
    logic signed [7:0] v;
    logic              clip;
  } rnd_t;

  typedef enum logic [1:0] {IDLE, MAC, DONE} state_t;

  // 16-bit product, one guard bit for the re/im difference, N bits of row growth
  function automatic int ACC_W(input int n);
    return 17 + n;
  endfunction

  // round half toward +inf, then clip to the signed 8-bit range
  function automatic rnd_t sat_round(input logic signed [31:0] acc, input int frac);
    logic signed [31:0] r;
    rnd_t o;
    r = (acc + (32'sd1 <<< (frac - 1))) >>> frac;
    o.clip = (r > 32'sd127) || (r < -32'sd128);
    o.v = (r > 32'sd127) ? 8'sd127 : (r < -32'sd128) ? -8'sd128 : r[7:0];
    return o;
  endfunction

endpackage

// File: rtl/gate_state_mac_engine_complex_mac.sv
// complex_mac: complex multiply of g*s added to a registered accumulator.
// acc_re/acc_im present the running sum including the current product, so a row can close in the same cycle.
module complex_mac
  import qc_pkg::*;
#(
  parameter int AW = 19
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clear,
  input  logic                 enable,
  input  complexNum            g,
  input  complexNum            s,
  output logic signed [AW-1:0] acc_re,
  output logic signed [AW-1:0] acc_im
);

  logic signed [AW-1:0] acc_re_q, acc_im_q;
  logic signed [15:0]   p_aa, p_bb, p_ab, p_ba;

  assign p_aa = $signed(g.a) * $signed(s.a);
  assign p_bb = $signed(g.b) * $signed(s.b);
  assign p_ab = $signed(g.a) * $signed(s.b);
  assign p_ba = $signed(g.b) * $signed(s.a);

  assign acc_re = acc_re_q + AW'(p_aa) - AW'(p_bb);
  assign acc_im = acc_im_q + AW'(p_ab) + AW'(p_ba);

  always_ff @(posedge clk) begin
    if (!reset || clear) begin
      acc_re_q <= '0;
      acc_im_q <= '0;
    end else if (enable) begin
      acc_re_q <= acc_re;
      acc_im_q <= acc_im;
    end
  end

endmodule

// File: rtl/gate_state_mac_engine.sv
// gate_state_mac_engine: sequential complex matrix-vector multiply out_state = gate x state.
// One gate element per cycle through a single complex MAC; results commit only in the DONE cycle.
module gate_state_mac_engine
  import qc_pkg::*;
#(
  parameter int N    = 2,
  parameter int FRAC = qc_pkg::FRAC
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic                                   start,
  input  complexNum [2**N-1:0]                   state_in,
  input  complexNum [2**N-1:0][2**N-1:0]         gate_in,
  output logic                                   busy,
  output logic                                   done,
  output complexNum [2**N-1:0]                   out_state,
  output logic                                   sat
);

  localparam int MAX = 2 ** N;
  localparam int AW  = ACC_W(N);
  localparam logic [N-1:0] LAST = N'(MAX - 1);

  state_t                           fsm_q;
  logic [N-1:0]                     row_q, col_q;
  complexNum [MAX-1:0]              st_q;
  complexNum [MAX-1:0][MAX-1:0]     g_q;
  complexNum [MAX-1:0]              res_q;
  logic                             sat_w_q;
  logic signed [AW-1:0]             sum_re, sum_im;
  logic                             row_end, mac_clr;
  rnd_t                             re, im;

  assign row_end = (fsm_q == MAC) && (col_q == LAST);
  assign mac_clr = ((fsm_q == IDLE) && start) || row_end;
  assign re      = sat_round(32'(sum_re), FRAC);
  assign im      = sat_round(32'(sum_im), FRAC);

  complex_mac #(.AW(AW)) u_mac (
    .clk    (clk),
    .reset  (reset),
    .clear  (mac_clr),
    .enable (fsm_q == MAC),
    .g      (g_q[row_q][col_q]),
    .s      (st_q[col_q]),
    .acc_re (sum_re),
    .acc_im (sum_im)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      fsm_q     <= IDLE;
      row_q     <= '0;
      col_q     <= '0;
      sat_w_q   <= 1'b0;
      res_q     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      sat       <= 1'b0;
      out_state <= '0;
    end else begin
      busy <= (fsm_q == MAC);
      done <= 1'b0;
      case (fsm_q)
        IDLE: if (start) begin
          st_q    <= state_in;
          g_q     <= gate_in;
          row_q   <= '0;
          col_q   <= '0;
          sat_w_q <= 1'b0;
          fsm_q   <= MAC;
        end
        MAC: if (col_q == LAST) begin
          res_q[row_q] <= '{a: re.v, b: im.v};
          sat_w_q      <= sat_w_q | re.clip | im.clip;
          col_q        <= '0;
          if (row_q == LAST) fsm_q <= DONE;
          else row_q <= row_q + 1'b1;
        end else begin
          col_q <= col_q + 1'b1;
        end
        DONE: begin
          out_state <= res_q;
          sat       <= sat_w_q;
          done      <= 1'b1;
          fsm_q     <= IDLE;
        end
        default: fsm_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gate_state_mac_engine.sv
// tb_gate_state_mac_engine: directed vectors with hand-computed results for the gate/state MAC engine.
module tb_gate_state_mac_engine;
  import qc_pkg::*;

  logic                       clk = 1'b0;
  logic                       reset = 1'b0;
  logic                       start = 1'b0;
  complexNum [3:0]            state_in;
  complexNum [3:0][3:0]       gate_in;
  logic                       busy, done, sat;
  complexNum [3:0]            out_state;

  int checks = 0;
  int errors = 0;
  int lat, bcnt, dcnt;

  gate_state_mac_engine #(.N(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .state_in  (state_in),
    .gate_in   (gate_in),
    .busy      (busy),
    .done      (done),
    .out_state (out_state),
    .sat       (sat)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input integer obs, input integer exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input integer ea[4], input integer eb[4]);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("%s_a%0d", tag, i), integer'($signed(out_state[i].a)), ea[i]);
      chk($sformatf("%s_b%0d", tag, i), integer'($signed(out_state[i].b)), eb[i]);
    end
  endtask

  // launch one operation, optionally pulsing start again after `extra` edges, and wait for done
  task automatic do_op(input int extra, output int l, output int b);
    l = -1;
    b = 0;
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    chk("busy_at_accept", busy, 0);
    for (int n = 1; n <= 40; n++) begin
      if (n == extra) start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      b += busy;
      if (done) begin
        l = n;
        break;
      end
    end
    chk("done_seen", (l > 0) ? 1 : 0, 1);
  endtask

  task automatic watch_done(input int cycles, output int cnt);
    cnt = 0;
    repeat (cycles) begin
      @(posedge clk); #1;
      cnt += done;
    end
  endtask

  task automatic load_identity();
    gate_in  = '0;
    state_in = '0;
    for (int i = 0; i < 4; i++) gate_in[i][i].a = 8'sd64;
    state_in[0].a = 8'sd64;
  endtask

  initial begin
    gate_in  = '0;
    state_in = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_sat", sat, 0);
    chk_out("rst_out", '{0, 0, 0, 0}, '{0, 0, 0, 0});
    reset = 1'b1;
    @(posedge clk); #1;

    load_identity();
    do_op(0, lat, bcnt);
    chk("id_latency", lat, 17);
    chk("id_busy_cycles", bcnt, 16);
    chk("id_sat", sat, 0);
    chk_out("id", '{64, 0, 0, 0}, '{0, 0, 0, 0});
    @(posedge clk); #1;
    chk("done_one_cycle", done, 0);
    chk_out("id_hold", '{64, 0, 0, 0}, '{0, 0, 0, 0});

    gate_in = '0;
    gate_in[0][1].a = 8'sd64;
    gate_in[1][0].a = 8'sd64;
    gate_in[2][3].a = 8'sd64;
    gate_in[3][2].a = 8'sd64;
    state_in = '0;
    state_in[0].a = 8'sd10;
    state_in[1].a = 8'sd20;
    state_in[2].a = 8'sd30;
    state_in[3].a = 8'sd40;
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    state_in = '0;
    gate_in  = '0;
    lat = -1;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      if (done) begin
        lat = n;
        break;
      end
    end
    chk("x_latency", lat, 17);
    chk_out("x", '{20, 10, 40, 30}, '{0, 0, 0, 0});

    gate_in  = '0;
    state_in = '0;
    for (int i = 0; i < 4; i++) gate_in[i][i].b = 8'sd64;
    state_in[0].a = 8'sd64;
    do_op(0, lat, bcnt);
    chk_out("ii", '{0, 0, 0, 0}, '{64, 0, 0, 0});

    gate_in  = '0;
    state_in = '0;
    gate_in[0][0].a = 8'sd32;
    state_in[0].a   = 8'sd1;
    do_op(0, lat, bcnt);
    chk("round_pos", integer'($signed(out_state[0].a)), 1);
    state_in[0].a = -8'sd1;
    do_op(0, lat, bcnt);
    chk("round_neg", integer'($signed(out_state[0].a)), 0);
    chk("round_sat", sat, 0);

    gate_in  = '0;
    state_in = '0;
    for (int r = 0; r < 4; r++) begin
      state_in[r].a = 8'sd127;
      for (int c = 0; c < 4; c++) gate_in[r][c].a = 8'sd127;
    end
    do_op(0, lat, bcnt);
    chk_out("satp", '{127, 127, 127, 127}, '{0, 0, 0, 0});
    chk("satp_flag", sat, 1);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) gate_in[r][c].a = -8'sd128;
    do_op(0, lat, bcnt);
    chk_out("satn", '{-128, -128, -128, -128}, '{0, 0, 0, 0});
    chk("satn_flag", sat, 1);

    load_identity();
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (5) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk); #1 reset = 1'b1;
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_sat", sat, 0);
    chk_out("midrst", '{0, 0, 0, 0}, '{0, 0, 0, 0});
    watch_done(25, dcnt);
    chk("midrst_no_done", dcnt, 0);
    do_op(0, lat, bcnt);
    chk("post_rst_latency", lat, 17);
    chk_out("post_rst", '{64, 0, 0, 0}, '{0, 0, 0, 0});

    do_op(5, lat, bcnt);
    chk("busy_start_latency", lat, 17);
    watch_done(25, dcnt);
    chk("busy_start_no_second_done", dcnt, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/gate_state_mac_engine.md
Name: gate_state_mac_engine

Overview:
Sequential complex matrix-vector multiplier. It computes outState = gate × state for an N-qubit system (2^N × 2^N gate, 2^N-entry state).
- Sits directly downstream of the UART/GPIO load FSM: consumes the loaded state and gate arrays and produces the outState vector that the FSM's send states stream back to the host.
- Uses a single complex MAC and iterates one gate element per cycle, trading latency for area.

Parameters:
N, 2, number of qubits
MAX, 2**N, vector length / matrix dimension (derived; do not override)
FRAC, 6, fractional bits of the Q1.6 signed amplitude format

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-low reset
start  input  1  request a multiply; sampled only in IDLE
state_in  input  MAX x complexNum  input state vector (a = real, b = imag)
gate_in  input  MAX x MAX x complexNum  gate matrix, [row][col]
busy  output  1  high from the cycle after start is accepted until done
done  output  1  one-cycle pulse; out_state is valid and updated in the same cycle
out_state  output  MAX x complexNum  result vector; held until the next done
sat  output  1  at least one result component saturated in the last operation; updated with done

Behaviour:
- Number format: each complexNum field is 8-bit signed Q1.6, so 64 = 1.0 and 45 ≈ 1/sqrt2.
- Reset (reset == 0 at a rising edge):
  - FSM goes to IDLE; row and col = 0; accumulators = 0.
  - busy = 0, done = 0, sat = 0, all out_state fields = 0.
  - Reset overrides every other input, including mid-operation; a partially computed result is discarded and never committed.
- FSM states: IDLE, MAC, DONE.
- IDLE:
  - If start = 1, snapshot state_in and gate_in into internal registers; clear row, col, accumulators and the working sat flag; go to MAC.
  - Later changes to the inputs do not affect the operation in progress.
- MAC, one cycle per (row, col):
  - acc_re += g.a*s.a − g.b*s.b
  - acc_im += g.a*s.b + g.b*s.a
  - Here g = gate[row][col] and s = state[col].
  - Each product is 16-bit signed. Accumulators are 16+1+N bits signed and never overflow internally.
- Row end (col == MAX−1):
  - Include the final product in the accumulator.
  - Round: add 2^(FRAC−1), then arithmetic shift right by FRAC.
  - Saturate to [−128, 127]. If clipped, set the working sat flag.
  - Write the result to result_buf[row]; clear the accumulators; col = 0.
  - If row == MAX−1, go to DONE; otherwise row = row+1.
  - Otherwise (col < MAX−1), col = col+1.
- DONE (exactly one cycle):
  - out_state = result_buf; sat = working sat flag; done = 1; busy = 0 on the next edge.
  - Return to IDLE. A start seen during DONE is ignored; the host must re-assert it in IDLE.
- Latency: with start sampled at edge k, done = 1 during the cycle after edge k + MAX² + 1. For N = 2 that is 17 edges.
- Next start: can be accepted at edge k + MAX² + 2.
- start while busy: ignored, with no queueing.
- out_state between operations: never changes except in the DONE cycle; the downstream send logic may read it at any time.
- Rounding of negative values: rounds half toward +infinity, e.g. −32 raw product → 0.

Decomposition:
- Shared package qc_pkg:
  - typedef complexNum (logic signed [7:0] a, b)
  - FRAC constant
  - derived accumulator-width function ACC_W(N)
- One sub-module, complex_mac:
  - Combinational complex multiply plus registered accumulate.
  - Inputs: clear, enable, g, s. Outputs: acc_re, acc_im.
- Rounding/saturation lives in the parent, as a package function sat_round().

Test Plan:
- Identity gate (diagonal a = 64), state {64, 0, 0, 0} real → out_state {64, 0, 0, 0}; sat = 0; done exactly 17 edges after start is sampled; busy high for 16 cycles.
- X on qubit 0 (permutation rows 0↔1, 2↔3, a = 64), state a = {10, 20, 30, 40} → out a = {20, 10, 40, 30}, b all 0.
- Imaginary gate i·I (diagonal b = 64), state a = {64, 0, 0, 0} → out[0] = (a 0, b 64).
- Rounding: gate[0][0].a = 32, state[0].a = 1, all else 0 → out[0].a = 1. Same with state[0].a = −1 → out[0].a = 0.
- Saturation: all gate.a = 127, all state.a = 127 → every out.a = 127, sat = 1. All gate.a = −128, state.a = 127 → every out.a = −128, sat = 1.
- Reset and start edge cases:
  - Assert reset (0) for one cycle at MAC cycle 5 → busy = 0, out_state all 0, no done pulse.
  - Then start with the identity test → correct result.
  - A start pulse while busy produces no second done.
